// File: rtl/axis_tx_stream_pkg.sv
// Shared constants for the AXI4-Stream transmit path.
// The stream width follows the board-level ADC/DAC AXIS width constants.
package axis_tx_stream_pkg;

    localparam int ADC_AXIS_DATAWIDTH = 256;
    localparam int DAC_AXIS_DATAWIDTH = 256;

    // Transmit and receive ends share one width; the ADC value is the reference.
    localparam int AXIS_DATA_WIDTH = ADC_AXIS_DATAWIDTH;

endpackage

// File: rtl/axis_tx_fifo_mem.sv
// Simple dual-port storage for the transmit FIFO.
// The read port is registered. Its address is the head pointer the top level
// will hold after this edge, so the head word is ready one edge after any
// pointer move. A write to that same slot is forwarded, which lets a word
// written into an empty FIFO be loaded on the very next edge.
module axis_tx_fifo_mem #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Next head word: forward a same-edge write into the slot being read.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
    end

    // Storage array write and registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_tx_stream.sv
// FIFO-buffered AXI4-Stream master with beat/starvation/overflow statistics.
//
// Handshakes: on both ports a transfer happens at a clock edge where valid
// and ready are both high. The input side never stalls the producer: a write
// offered while din_ready=0 is dropped and recorded in overflow. The output
// side holds m_tvalid and m_tdata constant from assertion until the edge
// where m_tready is seen high, whatever enable does in the meantime.
module axis_tx_stream
    import axis_tx_stream_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    enable,
    input  logic                    clr_stats,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    cnt,
    output logic [CNT_WIDTH-1:0]    starve_cnt,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  din_ready_q, din_ready_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  primed_q, primed_d;

    logic                  push, drop, pop, empty, full_d, handshake, starve_inc;
    logic [DATA_WIDTH-1:0] head_data;

    axis_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr_d[AW-1:0]),
        .rd_data (head_data)
    );

    // Next-state logic for pointers, output register and statistics.
    always_comb begin
        push       = din_valid & din_ready_q;
        drop       = din_valid & ~din_ready_q;
        empty      = (wr_ptr_q == rd_ptr_q);
        handshake  = m_tvalid_q & m_tready;
        // A new word enters the output register only when the slot is free
        // or being emptied this edge.
        pop        = enable & ~empty & (~m_tvalid_q | m_tready);
        starve_inc = enable & m_tready & ~m_tvalid_q & primed_q;

        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + PW'(push) - PW'(pop);
        full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                     (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        din_ready_d = ~full_d;

        m_tvalid_d = pop | (m_tvalid_q & ~m_tready);
        m_tdata_d  = m_tdata_q;
        if (pop) begin
            m_tdata_d = head_data;
        end

        // Starvation is only meaningful once the stream has started.
        primed_d = enable & (primed_q | handshake);

        cnt_d        = cnt_q + CNT_WIDTH'(handshake);
        starve_cnt_d = starve_cnt_q;
        if (starve_inc && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
        end
        if (clr_stats) begin
            cnt_d        = '0;
            starve_cnt_d = '0;
        end
        // A drop in the clearing cycle still leaves overflow set.
        overflow_d = drop | (overflow_q & ~clr_stats);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            din_ready_q  <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            cnt_q        <= '0;
            starve_cnt_q <= '0;
            overflow_q   <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            din_ready_q  <= din_ready_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            cnt_q        <= cnt_d;
            starve_cnt_q <= starve_cnt_d;
            overflow_q   <= overflow_d;
            primed_q     <= primed_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign level      = level_q;
    assign cnt        = cnt_q;
    assign starve_cnt = starve_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_axis_tx_stream.sv
// Bench for axis_tx_stream: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the stream.
module tb_axis_tx_stream;

    localparam int DW      = 256;
    localparam int DEPTH   = 16;
    localparam int CW      = 8;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int CNT_MOD = 1 << CW;
    localparam int CNT_MAX = CNT_MOD - 1;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          enable;
    logic          clr_stats;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [LW-1:0] level;
    logic [CW-1:0] cnt;
    logic [CW-1:0] starve_cnt;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: FIFO as a queue, plus the output beat.
    logic [DW-1:0] exp_q[$];
    bit            mdl_valid;
    logic [DW-1:0] mdl_data;
    bit            mdl_ready;
    int            mdl_cnt;
    int            mdl_starve;
    bit            mdl_ovf;
    bit            mdl_primed;

    axis_tx_stream #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .enable     (enable),
        .clr_stats  (clr_stats),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .level      (level),
        .cnt        (cnt),
        .starve_cnt (starve_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        mdl_valid  = 0;
        mdl_data   = '0;
        mdl_ready  = 0;
        mdl_cnt    = 0;
        mdl_starve = 0;
        mdl_ovf    = 0;
        mdl_primed = 0;
    endtask

    // One clock edge; the model applies the stream rules to the inputs seen
    // at that edge, then outputs are sampled 1 ns later.
    task automatic step();
        bit hs, ld, push, drop, st;
        @(posedge clk);
        hs   = mdl_valid && m_tready;
        ld   = enable && (exp_q.size() != 0) && (!mdl_valid || m_tready);
        push = din_valid && mdl_ready;
        drop = din_valid && !mdl_ready;
        st   = enable && m_tready && !mdl_valid && mdl_primed;
        if (ld) begin
            mdl_data  = exp_q.pop_front();
            mdl_valid = 1;
        end else if (hs) begin
            mdl_valid = 0;
        end
        if (push) exp_q.push_back(din);
        mdl_ready = exp_q.size() < DEPTH;
        if (clr_stats) begin
            mdl_cnt    = 0;
            mdl_starve = 0;
        end else begin
            if (hs) mdl_cnt = (mdl_cnt + 1) % CNT_MOD;
            if (st && mdl_starve < CNT_MAX) mdl_starve++;
        end
        mdl_ovf    = drop || (mdl_ovf && !clr_stats);
        mdl_primed = enable && (mdl_primed || hs);
        #1;
    endtask

    task automatic idle_inputs();
        din_valid = 0;
        din       = '0;
        enable    = 0;
        clr_stats = 0;
        m_tready  = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        aresetn = 0;
        model_clear();
        #2;
        aresetn = 1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 0;
        #3;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %0b want 0", m_tvalid); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL rst_tdata: got %0h want 0", m_tdata); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", din_ready); end
        total++; if (level !== '0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
        total++; if (starve_cnt !== '0) begin bad++; $display("FAIL rst_starve: got %0d want 0", starve_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", overflow); end
        model_clear();
        aresetn = 1;
        step();
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %0b want 1", din_ready); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] w;
        apply_reset();
        enable   = 1;
        m_tready = 1;
        for (int i = 1; i <= 4; i++) begin
            din       = DW'(i);
            din_valid = 1;
            step();
            w = DW'(i - 1);
            if (i == 1) begin
                total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %0b want 0", m_tvalid); end
            end else begin
                total++; if (m_tvalid !== 1'b1 || m_tdata !== w) begin
                    bad++; $display("FAIL basic_beat%0d: got v=%0b d=%0h want v=1 d=%0h", i - 1, m_tvalid, m_tdata, w);
                end
            end
        end
        din_valid = 0;
        step();
        w = DW'(4);
        total++; if (m_tvalid !== 1'b1 || m_tdata !== w) begin bad++; $display("FAIL basic_beat4: got v=%0b d=%0h want v=1 d=4", m_tvalid, m_tdata); end
        step();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_end_valid: got %0b want 0", m_tvalid); end
        total++; if (cnt !== 8'd4) begin bad++; $display("FAIL basic_cnt: got %0d want 4", cnt); end
        total++; if (level !== '0) begin bad++; $display("FAIL basic_level: got %0d want 0", level); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] first;
        apply_reset();
        enable   = 1;
        m_tready = 0;
        for (int i = 0; i < 20; i++) begin
            din       = rand_word();
            din_valid = 1;
            if (i == 0) first = din;
            step();
            total++; if (level !== LW'(exp_q.size())) begin bad++; $display("FAIL fill_level: got %0d want %0d", level, exp_q.size()); end
            total++; if (din_ready !== mdl_ready) begin bad++; $display("FAIL fill_ready: got %0b want %0b", din_ready, mdl_ready); end
            if (i >= 1) begin
                total++; if (m_tvalid !== 1'b1 || m_tdata !== first) begin
                    bad++; $display("FAIL fill_stall_hold: got v=%0b d=%0h want v=1 d=%0h", m_tvalid, m_tdata, first);
                end
            end
        end
        din_valid = 0;
        total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL fill_full_level: got %0d want %0d", level, DEPTH); end
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready: got %0b want 0", din_ready); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %0b want 1", overflow); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] aa, bb;
        aa = DW'(8'hAA);
        bb = DW'(8'hBB);
        apply_reset();
        enable    = 1;
        m_tready  = 0;
        din       = aa;
        din_valid = 1;
        step();
        din = bb;
        step();
        din_valid = 0;
        step();
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (m_tvalid !== 1'b1 || m_tdata !== aa) begin bad++; $display("FAIL hold_aa: got v=%0b d=%0h want v=1 d=aa", m_tvalid, m_tdata); end
        end
        m_tready = 1;
        step();
        m_tready = 0;
        total++; if (cnt !== 8'd1) begin bad++; $display("FAIL hold_cnt: got %0d want 1", cnt); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL hold_drop_valid: got %0b want 0", m_tvalid); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (m_tvalid !== 1'b0 || level !== LW'(1)) begin bad++; $display("FAIL hold_no_load: got v=%0b lvl=%0d want v=0 lvl=1", m_tvalid, level); end
        end
        enable = 1;
        step();
        total++; if (m_tvalid !== 1'b1 || m_tdata !== bb) begin bad++; $display("FAIL hold_resume: got v=%0b d=%0h want v=1 d=bb", m_tvalid, m_tdata); end
    endtask

    task automatic test_starve_and_wrap();
        int guard;
        apply_reset();
        enable    = 1;
        m_tready  = 1;
        din       = rand_word();
        din_valid = 1;
        step();
        din_valid = 0;
        step();
        step();
        total++; if (cnt !== 8'd1) begin bad++; $display("FAIL starve_first_hs: got %0d want 1", cnt); end
        repeat (10) step();
        total++; if (starve_cnt !== 8'd10) begin bad++; $display("FAIL starve_ten: got %0d want 10", starve_cnt); end
        // Stream until the beat counter sits at all-ones, then one more beat.
        guard = 0;
        din_valid = 1;
        while (mdl_cnt != CNT_MAX && guard < 1000) begin
            din = rand_word();
            step();
            guard++;
        end
        total++; if (cnt !== 8'hFF) begin bad++; $display("FAIL cnt_at_max: got %0d want 255", cnt); end
        din = rand_word();
        step();
        total++; if (cnt !== 8'h00) begin bad++; $display("FAIL cnt_wrap: got %0d want 0", cnt); end
        total++; if (starve_cnt !== mdl_starve[CW-1:0]) begin bad++; $display("FAIL starve_stream: got %0d want %0d", starve_cnt, mdl_starve); end
        din_valid = 0;
        repeat (300) step();
        total++; if (starve_cnt !== 8'hFF) begin bad++; $display("FAIL starve_sat: got %0d want 255", starve_cnt); end
    endtask

    task automatic test_clr();
        // Continues from a saturated starve count and an empty FIFO.
        m_tready  = 0;
        din_valid = 1;
        for (int i = 0; i < 17; i++) begin
            din = rand_word();
            step();
        end
        total++; if (din_ready !== 1'b0 || level !== LW'(DEPTH)) begin bad++; $display("FAIL clr_setup: got rdy=%0b lvl=%0d want rdy=0 lvl=16", din_ready, level); end
        m_tready  = 1;
        clr_stats = 1;
        din       = rand_word();
        step();
        total++; if (cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", cnt); end
        total++; if (starve_cnt !== 8'd0) begin bad++; $display("FAIL clr_starve: got %0d want 0", starve_cnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_ovf_drop: got %0b want 1", overflow); end
        total++; if (level !== LW'(exp_q.size())) begin bad++; $display("FAIL clr_level: got %0d want %0d", level, exp_q.size()); end
        din_valid = 0;
        m_tready  = 0;
        step();
        clr_stats = 0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enable    = 1;
        m_tready  = 0;
        din_valid = 1;
        for (int i = 0; i < 8; i++) begin
            din = rand_word();
            step();
        end
        din_valid = 0;
        total++; if (level !== LW'(7) || m_tvalid !== 1'b1) begin bad++; $display("FAIL mid_setup: got lvl=%0d v=%0b want lvl=7 v=1", level, m_tvalid); end
        aresetn = 0;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b want 0", m_tvalid); end
        total++; if (level !== '0) begin bad++; $display("FAIL mid_rst_level: got %0d want 0", level); end
        model_clear();
        #1;
        aresetn  = 1;
        m_tready = 1;
        step();
        total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %0b want 1", din_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (m_tvalid !== 1'b0 || cnt !== 8'd0) begin bad++; $display("FAIL mid_stale: got v=%0b cnt=%0d want v=0 cnt=0", m_tvalid, cnt); end
        end
    endtask

    task automatic test_random();
        int tready_pct [4] = '{20, 90, 50, 70};
        int valid_pct  [4] = '{90, 40, 60, 80};
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 500; i++) begin
                din       = rand_word();
                din_valid = ($urandom_range(0, 99) < valid_pct[p]);
                m_tready  = ($urandom_range(0, 99) < tready_pct[p]);
                enable    = ($urandom_range(0, 99) < 85);
                clr_stats = ($urandom_range(0, 49) == 0);
                step();
                total++; if (m_tvalid !== mdl_valid) begin bad++; $display("FAIL rnd_valid: got %0b want %0b", m_tvalid, mdl_valid); end
                total++; if (m_tdata !== mdl_data) begin bad++; $display("FAIL rnd_data: got %0h want %0h", m_tdata, mdl_data); end
                total++; if (din_ready !== mdl_ready) begin bad++; $display("FAIL rnd_ready: got %0b want %0b", din_ready, mdl_ready); end
                total++; if (level !== LW'(exp_q.size())) begin bad++; $display("FAIL rnd_level: got %0d want %0d", level, exp_q.size()); end
                total++; if (cnt !== mdl_cnt[CW-1:0]) begin bad++; $display("FAIL rnd_cnt: got %0d want %0d", cnt, mdl_cnt); end
                total++; if (starve_cnt !== mdl_starve[CW-1:0]) begin bad++; $display("FAIL rnd_starve: got %0d want %0d", starve_cnt, mdl_starve); end
                total++; if (overflow !== mdl_ovf) begin bad++; $display("FAIL rnd_ovf: got %0b want %0b", overflow, mdl_ovf); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        aresetn = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_fill();
        test_hold();
        test_starve_and_wrap();
        test_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
